// File: rtl/silencer_rate_limiter_pkg.sv
// Shared types and constants for the per-frame intensity/phase rate limiter.
// Holds the settings word layout, the pipeline latency and the controller states.
package silencer_rate_limiter_pkg;

  localparam int RATE_WIDTH       = 16;
  localparam int SILENCER_LATENCY = 3;

  typedef struct packed {
    logic [RATE_WIDTH-1:0] update_rate_intensity;
    logic [RATE_WIDTH-1:0] update_rate_phase;
  } silencer_rate_settings_t;

  typedef enum logic {
    ST_CLEAR,
    ST_RUN
  } silencer_state_e;

endpackage

// File: rtl/silencer_rate_limiter_if.sv
// Beat-level bus between the modulation stage (master) and the rate limiter (slave).
// Carries target beats and frame settings in, and limited beats plus the settled flag out.
interface silencer_rate_limiter_if #(
  parameter int INTENSITY_WIDTH = 16,
  parameter int PHASE_WIDTH     = 8
);
  import silencer_rate_limiter_pkg::*;

  silencer_rate_settings_t      settings;
  logic                         tgt_valid;
  logic [INTENSITY_WIDTH-1:0]   tgt_intensity;
  logic [PHASE_WIDTH-1:0]       tgt_phase;
  logic                         ready;
  logic                         lim_valid;
  logic [INTENSITY_WIDTH-1:0]   lim_intensity;
  logic [PHASE_WIDTH-1:0]       lim_phase;
  logic                         settled;

  modport master (
    output settings, tgt_valid, tgt_intensity, tgt_phase,
    input  ready, lim_valid, lim_intensity, lim_phase, settled
  );

  modport slave (
    input  settings, tgt_valid, tgt_intensity, tgt_phase,
    output ready, lim_valid, lim_intensity, lim_phase, settled
  );

endinterface

// File: rtl/silencer_rate_limiter_step_unit.sv
// One bounded move of a value toward its target: next = step(cur, target, rate).
// WRAP=1 treats the value as modular and takes the shortest path, a half turn going upward.
module silencer_rate_limiter_step_unit #(
  parameter int W    = 16,
  parameter int RW   = 16,
  parameter bit WRAP = 1'b0
) (
  input  logic [W-1:0]  cur,
  input  logic [W-1:0]  tgt,
  input  logic [RW-1:0] rate,
  output logic [W-1:0]  nxt
);
  localparam int CW = (W + 1 > RW) ? W + 1 : RW;
  localparam logic [W-1:0] HALF = {1'b1, {(W-1){1'b0}}};

  logic [W-1:0]      raw;
  logic signed [W:0] diff;
  logic              neg;
  logic [W:0]        mag;
  logic [CW-1:0]     mag_x;
  logic [CW-1:0]     rate_x;
  logic [W-1:0]      rate_w;

  assign raw = tgt - cur;

  always_comb begin
    if (WRAP) begin
      // An exact half turn is kept positive so it resolves in the + direction.
      diff = (raw == HALF) ? {1'b0, raw} : {raw[W-1], raw};
    end else begin
      diff = {1'b0, tgt} - {1'b0, cur};
    end
    neg    = diff[W];
    mag    = neg ? $unsigned(-diff) : $unsigned(diff);
    mag_x  = CW'(mag);
    rate_x = CW'(rate);
    rate_w = W'(rate);

    if (rate == '0) begin
      nxt = cur;
    end else if (mag_x <= rate_x) begin
      nxt = tgt;
    end else begin
      nxt = neg ? (cur - rate_w) : (cur + rate_w);
    end
  end

endmodule

// File: rtl/silencer_rate_limiter.sv
// Per-frame rate limiter between the modulation and PWM stages: each channel's intensity and
// phase move toward their targets by at most the frame's programmed step, with a clear sweep after reset.
module silencer_rate_limiter
  import silencer_rate_limiter_pkg::*;
#(
  parameter int DEPTH           = 249,
  parameter int INTENSITY_WIDTH = 16,
  parameter int PHASE_WIDTH     = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  silencer_rate_limiter_if.slave bus
);
  localparam int ACC_W = PHASE_WIDTH + 8;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  silencer_state_e         state;
  logic [AW-1:0]           clr_addr;
  logic [AW-1:0]           idx;
  logic                    ready;
  logic                    accept;
  silencer_rate_settings_t frame_rates;
  silencer_rate_settings_t beat_rates;

  logic [INTENSITY_WIDTH-1:0] int_mem [DEPTH];
  logic [ACC_W-1:0]           ph_mem  [DEPTH];
  logic                       wr_en;
  logic [AW-1:0]              wr_addr;
  logic [INTENSITY_WIDTH-1:0] wr_int;
  logic [ACC_W-1:0]           wr_ph;

  logic                       vld_p0;
  logic [AW-1:0]              idx_p0;
  logic [INTENSITY_WIDTH-1:0] tgt_int_p0;
  logic [PHASE_WIDTH-1:0]     tgt_ph_p0;
  logic [INTENSITY_WIDTH-1:0] cur_int_p0;
  logic [ACC_W-1:0]           cur_ph_p0;
  silencer_rate_settings_t    rates_p0;

  logic [INTENSITY_WIDTH-1:0] nxt_int;
  logic [ACC_W-1:0]           nxt_ph;

  logic                       vld_p1;
  logic [AW-1:0]              idx_p1;
  logic [INTENSITY_WIDTH-1:0] tgt_int_p1;
  logic [PHASE_WIDTH-1:0]     tgt_ph_p1;
  logic [INTENSITY_WIDTH-1:0] nxt_int_p1;
  logic [ACC_W-1:0]           nxt_ph_p1;
  logic                       match_p1;
  logic                       settle_next;

  logic                       vld_p2;
  logic [INTENSITY_WIDTH-1:0] int_p2;
  logic [PHASE_WIDTH-1:0]     ph_p2;
  logic                       settle_acc;
  logic                       settled;

  assign accept     = bus.tgt_valid & ready;
  assign beat_rates = (idx == '0) ? bus.settings : frame_rates;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_CLEAR;
      clr_addr <= '0;
      ready    <= 1'b0;
      idx      <= '0;
    end else begin
      case (state)
        ST_CLEAR: begin
          if (clr_addr == LAST_IDX) begin
            state    <= ST_RUN;
            ready    <= 1'b1;
            clr_addr <= '0;
          end else begin
            clr_addr <= clr_addr + 1'b1;
          end
        end
        ST_RUN: begin
          state <= ST_RUN;
          ready <= 1'b1;
        end
        default: begin
          state <= ST_CLEAR;
          ready <= 1'b0;
        end
      endcase
      if (accept) begin
        idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
      end
    end
  end

  // Rates seen on the index-0 beat govern the whole frame.
  always_ff @(posedge clk) begin
    if (accept && (idx == '0)) begin
      frame_rates <= bus.settings;
    end
  end

  // p0: register the beat and read both state memories
  always_ff @(posedge clk) begin
    tgt_int_p0 <= bus.tgt_intensity;
    tgt_ph_p0  <= bus.tgt_phase;
    idx_p0     <= idx;
    rates_p0   <= beat_rates;
    cur_int_p0 <= int_mem[idx];
    cur_ph_p0  <= ph_mem[idx];
  end

  always_ff @(posedge clk) begin
    if (rst) vld_p0 <= 1'b0;
    else     vld_p0 <= accept;
  end

  silencer_rate_limiter_step_unit #(
    .W    (INTENSITY_WIDTH),
    .RW   (RATE_WIDTH),
    .WRAP (1'b0)
  ) u_step_int (
    .cur  (cur_int_p0),
    .tgt  (tgt_int_p0),
    .rate (rates_p0.update_rate_intensity),
    .nxt  (nxt_int)
  );

  silencer_rate_limiter_step_unit #(
    .W    (ACC_W),
    .RW   (RATE_WIDTH),
    .WRAP (1'b1)
  ) u_step_ph (
    .cur  (cur_ph_p0),
    .tgt  ({tgt_ph_p0, 8'h00}),
    .rate (rates_p0.update_rate_phase),
    .nxt  (nxt_ph)
  );

  // p1: register the stepped values
  always_ff @(posedge clk) begin
    idx_p1     <= idx_p0;
    tgt_int_p1 <= tgt_int_p0;
    tgt_ph_p1  <= tgt_ph_p0;
    nxt_int_p1 <= nxt_int;
    nxt_ph_p1  <= nxt_ph;
  end

  always_ff @(posedge clk) begin
    if (rst) vld_p1 <= 1'b0;
    else     vld_p1 <= vld_p0;
  end

  // The clear sweep owns the write port; in RUN the p1 beat writes back its channel.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = idx_p1;
    wr_int  = nxt_int_p1;
    wr_ph   = nxt_ph_p1;
    if (state == ST_CLEAR) begin
      wr_en   = 1'b1;
      wr_addr = clr_addr;
      wr_int  = '0;
      wr_ph   = '0;
    end else if (vld_p1) begin
      wr_en   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      int_mem[wr_addr] <= wr_int;
      ph_mem[wr_addr]  <= wr_ph;
    end
  end

  assign match_p1    = (nxt_int_p1 == tgt_int_p1) &&
                       (nxt_ph_p1[ACC_W-1 -: PHASE_WIDTH] == tgt_ph_p1);
  assign settle_next = match_p1 & ((idx_p1 == '0) | settle_acc);

  // p2: output register and frame-end settled flag
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p2     <= 1'b0;
      int_p2     <= '0;
      ph_p2      <= '0;
      settle_acc <= 1'b0;
      settled    <= 1'b0;
    end else begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        int_p2     <= nxt_int_p1;
        ph_p2      <= nxt_ph_p1[ACC_W-1 -: PHASE_WIDTH];
        settle_acc <= settle_next;
        if (idx_p1 == LAST_IDX) begin
          settled <= settle_next;
        end
      end
    end
  end

  assign bus.ready         = ready;
  assign bus.lim_valid     = vld_p2;
  assign bus.lim_intensity = int_p2;
  assign bus.lim_phase     = ph_p2;
  assign bus.settled       = settled;

endmodule

// File: tb/tb_silencer_rate_limiter.sv
// Directed and randomised bench for silencer_rate_limiter with a small behavioural model.
module tb_silencer_rate_limiter;
  import silencer_rate_limiter_pkg::*;

  localparam int DEPTH = 16;
  localparam int IW    = 16;
  localparam int PW    = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  silencer_rate_limiter_if #(.INTENSITY_WIDTH(IW), .PHASE_WIDTH(PW)) bus ();

  silencer_rate_limiter #(
    .DEPTH           (DEPTH),
    .INTENSITY_WIDTH (IW),
    .PHASE_WIDTH     (PW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int          in_cyc_q[$];
  logic [31:0] out_q[$];
  logic [31:0] exp_q[$];

  int m_i[DEPTH];
  int m_p[DEPTH];
  int m_idx, m_ri, m_rp;
  bit m_match, m_settled;

  int vt_i[DEPTH];
  int vt_p[DEPTH];
  int fr_i[DEPTH];
  int fr_p[DEPTH];
  int fr_l[DEPTH];
  int fr_s;

  // Output beat record: {latency[6:0], settled, intensity, phase}
  always @(negedge clk) begin
    int c0;
    if (bus.lim_valid) begin
      c0 = (in_cyc_q.size() > 0) ? in_cyc_q.pop_front() : 0;
      out_q.push_back({7'(cyc - c0), bus.settled, bus.lim_intensity, bus.lim_phase});
    end
  end

  task automatic chk(string tag, longint got, longint want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, want);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < DEPTH; k++) begin
      m_i[k] = 0;
      m_p[k] = 0;
    end
    m_idx = 0; m_ri = 0; m_rp = 0;
    m_match = 1'b0; m_settled = 1'b0;
  endtask

  task automatic model_step(int ti, int tp, int ri, int rp);
    int d;
    bit match;
    if (m_idx == 0) begin
      m_ri = ri;
      m_rp = rp;
    end
    d = ti - m_i[m_idx];
    if (m_ri != 0) begin
      if (((d < 0) ? -d : d) <= m_ri) m_i[m_idx] = ti;
      else m_i[m_idx] = m_i[m_idx] + ((d > 0) ? m_ri : -m_ri);
    end
    d = (tp * 256 - m_p[m_idx]) & 32'hFFFF;
    if (d > 32768) d = d - 65536;
    if (m_rp != 0) begin
      if (((d < 0) ? -d : d) <= m_rp) m_p[m_idx] = tp * 256;
      else m_p[m_idx] = (m_p[m_idx] + ((d > 0) ? m_rp : -m_rp)) & 32'hFFFF;
    end
    match = (m_i[m_idx] == ti) && ((m_p[m_idx] >> 8) == tp);
    m_match = (m_idx == 0) ? match : (m_match && match);
    if (m_idx == DEPTH - 1) m_settled = m_match;
    exp_q.push_back({7'(SILENCER_LATENCY), m_settled, 16'(m_i[m_idx]), 8'(m_p[m_idx] >> 8)});
    m_idx = (m_idx + 1) % DEPTH;
  endtask

  task automatic drive_beat(int ti, int tp, int ri, int rp);
    bus.tgt_valid = 1'b1;
    bus.tgt_intensity = IW'(ti);
    bus.tgt_phase = PW'(tp);
    bus.settings.update_rate_intensity = RATE_WIDTH'(ri);
    bus.settings.update_rate_phase = RATE_WIDTH'(rp);
    if (bus.ready) begin
      in_cyc_q.push_back(cyc);
      model_step(ti, tp, ri, rp);
    end
    @(posedge clk); #1;
    bus.tgt_valid = 1'b0;
  endtask

  task automatic set_uniform(int ti, int tp);
    for (int k = 0; k < DEPTH; k++) begin
      vt_i[k] = ti;
      vt_p[k] = tp;
    end
  endtask

  task automatic drive_frame(int ri, int rp, int chg, int ri2, int rp2, int gap_at);
    for (int b = 0; b < DEPTH; b++) begin
      if (b == gap_at) repeat (3) begin @(posedge clk); #1; end
      if (b < chg) drive_beat(vt_i[b], vt_p[b], ri, rp);
      else         drive_beat(vt_i[b], vt_p[b], ri2, rp2);
    end
  endtask

  task automatic drain(string tag);
    int n;
    int pos;
    logic [31:0] o, e;
    n = 0;
    pos = 0;
    while ((out_q.size() < exp_q.size()) && (n < 20)) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_count"}, out_q.size(), exp_q.size());
    while ((out_q.size() > 0) && (exp_q.size() > 0)) begin
      o = out_q.pop_front();
      e = exp_q.pop_front();
      chk($sformatf("%s_beat%0d", tag, pos), o, e);
      if (pos < DEPTH) begin
        fr_i[pos] = int'(o[23:8]);
        fr_p[pos] = int'(o[7:0]);
        fr_l[pos] = int'(o[31:25]);
      end
      fr_s = int'(o[24]);
      pos++;
    end
    out_q.delete();
    exp_q.delete();
  endtask

  task automatic chk_frame(string tag, int ei, int ep, int es);
    chk({tag, "_first"}, fr_i[0] * 256 + fr_p[0], ei * 256 + ep);
    chk({tag, "_last"}, fr_i[DEPTH-1] * 256 + fr_p[DEPTH-1], ei * 256 + ep);
    chk({tag, "_settled"}, fr_s, es);
  endtask

  task automatic after_reset(string tag);
    int n;
    chk({tag, "_valid"}, bus.lim_valid, 0);
    chk({tag, "_outs"}, {bus.ready, bus.settled, bus.lim_intensity, bus.lim_phase}, 0);
    in_cyc_q.delete();
    out_q.delete();
    exp_q.delete();
    model_reset();
    n = 0;
    while (!bus.ready && (n < 4 * DEPTH)) begin
      drive_beat(7, 7, 1, 1);
      n++;
    end
    chk({tag, "_clear_len"}, n, DEPTH);
    repeat (4) begin @(posedge clk); #1; end
    chk({tag, "_clear_drop"}, out_q.size(), 0);
  endtask

  task automatic do_reset(string tag);
    rst = 1'b1;
    bus.tgt_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    after_reset(tag);
  endtask

  initial begin
    int ri, rp, mn, nf;
    bit all_eq;
    bus.tgt_valid = 1'b0;
    bus.tgt_intensity = '0;
    bus.tgt_phase = '0;
    bus.settings = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    do_reset("rst0");

    // Unit steps; the third frame wraps the phase through 0 to 255.
    set_uniform(1, 1);
    drive_frame(1, 256, DEPTH, 0, 0, -1);
    drain("basic1");
    chk_frame("basic1", 1, 1, 1);
    set_uniform(256, 255);
    drive_frame(1, 256, DEPTH, 0, 0, -1);
    drain("basic2");
    chk_frame("basic2", 2, 0, 0);
    set_uniform(3, 255);
    drive_frame(1, 256, DEPTH, 0, 0, -1);
    drain("basic3");
    chk_frame("basic3", 3, 255, 1);

    do_reset("rst1");
    set_uniform(65025, 128);
    drive_frame(65535, 65535, DEPTH, 0, 0, -1);
    drain("snap1");
    chk_frame("snap1", 65025, 128, 1);
    set_uniform(0, 0);
    drive_frame(65535, 65535, DEPTH, 0, 0, -1);
    drain("snap2");
    chk_frame("snap2", 0, 0, 1);

    // Half turn resolves upward; then a zero phase rate holds.
    do_reset("rst2");
    set_uniform(0, 128);
    drive_frame(1, 256, DEPTH, 0, 0, -1);
    drain("tie");
    chk_frame("tie", 0, 1, 0);
    for (int f = 0; f < 3; f++) begin
      drive_frame(1, 0, DEPTH, 0, 0, -1);
      drain($sformatf("hold%0d", f));
      chk_frame($sformatf("hold%0d", f), 0, 1, 0);
    end

    // Rates change at beat 10 (with a gap at beat 5); the frame keeps the old rates.
    set_uniform(1000, 200);
    drive_frame(1, 256, 10, 500, 65535, 5);
    drain("latch1");
    chk_frame("latch1", 1, 0, 0);
    chk("latch1_lat_b0", fr_l[0], SILENCER_LATENCY);
    chk("latch1_lat_b12", fr_l[12], SILENCER_LATENCY);
    chk("latch1_b12", fr_i[12] * 256 + fr_p[12], 1 * 256 + 0);
    drive_frame(500, 65535, DEPTH, 0, 0, -1);
    drain("latch2");
    chk_frame("latch2", 501, 200, 0);

    for (int r = 0; r < 100; r++) begin
      ri = $urandom_range(65535, 8192);
      rp = $urandom_range(65535, 8192);
      mn = (ri < rp) ? ri : rp;
      nf = (65536 + mn - 1) / mn + 1;
      for (int b = 0; b < DEPTH; b++) begin
        vt_i[b] = $urandom_range(65535, 0);
        vt_p[b] = $urandom_range(255, 0);
      end
      for (int f = 0; f < nf; f++) begin
        drive_frame(ri, rp, DEPTH, 0, 0, -1);
        drain("rand");
      end
      all_eq = 1'b1;
      for (int b = 0; b < DEPTH; b++) begin
        if ((fr_i[b] != vt_i[b]) || (fr_p[b] != vt_p[b])) all_eq = 1'b0;
      end
      chk($sformatf("rand%0d_final", r), {all_eq, fr_s[0]}, 2'b11);
    end

    // Reset in the middle of a frame with beats still in flight.
    set_uniform(9, 9);
    for (int b = 0; b < 7; b++) drive_beat(vt_i[b], vt_p[b], 1, 256);
    rst = 1'b1;
    bus.tgt_valid = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    bus.tgt_valid = 1'b0;
    after_reset("midrst");
    set_uniform(5, 5);
    drive_frame(1, 256, DEPTH, 0, 0, -1);
    drain("restart");
    chk_frame("restart", 1, 1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
